// File: rtl/crc32_pkg.sv
// Shared constants, state encoding and the bit-serial CRC step
// for the CRC-32 frame receive path.
package crc32_pkg;

    localparam logic [31:0] CRC_INIT         = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_DEFAULT = 32'hEDB8_8320;
    localparam int          MIN_FRAME        = 5;
    localparam int          CRC_BYTES        = 4;

    typedef enum logic [1:0] {
        ST_RX    = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // One step of a reflected (right-shifting) CRC LFSR.
    function automatic logic [31:0] crc_bit_step(
        input logic [31:0] lfsr,
        input logic        din,
        input logic [31:0] poly
    );
        logic fb;
        fb = lfsr[0] ^ din;
        return (lfsr >> 1) ^ (fb ? poly : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_serial_engine.sv
// Bit-serial CRC-32 LFSR: one data bit per enabled cycle, LSB-first order.
module crc32_serial_engine
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = CRC_POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [31:0] o_lfsr
);

    logic [31:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst || i_init) begin
            r_lfsr <= CRC_INIT;
        end else if (i_en) begin
            r_lfsr <= crc_bit_step(r_lfsr, i_bit, POLY);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/crc32_frame_rx_ctrl.sv
// Frame receive sequencer: withholds the trailing 4 bytes, serializes payload
// into the CRC engine and reports a per-frame verdict with statistics.
module crc32_frame_rx_ctrl
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY      = CRC_POLY_DEFAULT,
    parameter int          MAX_BYTES = 1518,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             frame_err,
    output logic             err_runt,
    output logic             err_oversize,
    output logic [31:0]      crc_calc,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int              BC_W   = $clog2(MAX_BYTES + 2);
    localparam logic [BC_W-1:0] MAX_BC = BC_W'(MAX_BYTES);

    state_t             r_state;
    logic [3:0][7:0]    r_dly;
    logic [2:0]         r_fill;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [BC_W-1:0]    r_byte_cnt;
    logic               r_oversize;
    logic               r_runt;
    logic               r_ready;

    logic               r_done;
    logic               r_ok;
    logic               r_err;
    logic               r_err_runt;
    logic               r_err_over;
    logic [31:0]        r_crc;
    logic [CNT_W-1:0]   r_fcnt;
    logic [CNT_W-1:0]   r_ecnt;

    logic               w_accept;
    logic               w_shift_en;
    logic [31:0]        w_lfsr;
    logic [31:0]        w_crc_final;
    logic [31:0]        w_rx_crc;
    logic               w_ok_chk;
    logic [BC_W-1:0]    w_byte_cnt_nxt;
    logic               w_over_nxt;

    assign w_accept       = s_valid && r_ready;
    assign w_shift_en     = (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
    assign w_crc_final    = w_lfsr ^ CRC_XOROUT;
    // Oldest delay-line byte is the least significant CRC byte.
    assign w_rx_crc       = r_dly;
    assign w_ok_chk       = (w_crc_final == w_rx_crc) && !r_runt && !r_oversize;
    assign w_byte_cnt_nxt = (r_byte_cnt == '1) ? r_byte_cnt : r_byte_cnt + BC_W'(1);
    assign w_over_nxt     = r_oversize || (w_byte_cnt_nxt > MAX_BC);

    crc32_serial_engine #(
        .POLY (POLY)
    ) u_engine (
        .clk    (clk),
        .rst    (rst),
        .i_init (r_state == ST_CHECK),
        .i_en   (w_shift_en),
        .i_bit  (r_shift[0]),
        .o_lfsr (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RX;
            r_dly      <= '0;
            r_fill     <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_oversize <= 1'b0;
            r_runt     <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_err_runt <= 1'b0;
            r_err_over <= 1'b0;
            r_crc      <= '0;
            r_fcnt     <= '0;
            r_ecnt     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_RX: begin
                    if (w_accept) begin
                        r_byte_cnt <= w_byte_cnt_nxt;
                        r_oversize <= w_over_nxt;
                        if (r_fill == 3'd4) begin
                            r_shift   <= r_dly[0];
                            r_dly     <= {s_data, r_dly[3:1]};
                            r_bit_cnt <= '0;
                            r_ready   <= 1'b0;
                            r_state   <= s_last ? ST_DRAIN : ST_SHIFT;
                        end else begin
                            r_dly[r_fill[1:0]] <= s_data;
                            r_fill             <= r_fill + 3'd1;
                            if (s_last) begin
                                r_runt  <= 1'b1;
                                r_ready <= 1'b0;
                                r_state <= ST_CHECK;
                            end
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end

                ST_SHIFT, ST_DRAIN: begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (r_state == ST_SHIFT) begin
                            r_ready <= 1'b1;
                            r_state <= ST_RX;
                        end else begin
                            r_state <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    r_done     <= 1'b1;
                    r_ok       <= w_ok_chk;
                    r_err      <= !w_ok_chk;
                    r_err_runt <= r_runt;
                    r_err_over <= r_oversize;
                    r_crc      <= w_crc_final;
                    if (r_fcnt != '1) r_fcnt <= r_fcnt + CNT_W'(1);
                    if (!w_ok_chk && (r_ecnt != '1)) r_ecnt <= r_ecnt + CNT_W'(1);
                    r_fill     <= '0;
                    r_byte_cnt <= '0;
                    r_runt     <= 1'b0;
                    r_oversize <= 1'b0;
                    r_ready    <= 1'b1;
                    r_state    <= ST_RX;
                end

                default: r_state <= ST_RX;
            endcase
        end
    end

    assign s_ready      = r_ready;
    assign busy         = (r_fill != 3'd0) || (r_state != ST_RX);
    assign frame_done   = r_done;
    assign frame_ok     = r_ok;
    assign frame_err    = r_err;
    assign err_runt     = r_err_runt;
    assign err_oversize = r_err_over;
    assign crc_calc     = r_crc;
    assign frame_count  = r_fcnt;
    assign err_count    = r_ecnt;

endmodule

// File: tb/tb_crc32_frame_rx_ctrl.sv
// Directed bench for crc32_frame_rx_ctrl: default instance plus a MAX_BYTES=8
// instance for the oversize case, sharing the byte bus.
module tb_crc32_frame_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_vld;
    logic        s_last;
    logic        sel;
    logic        s_valid_a, s_valid_b;

    logic        a_ready, a_busy, a_done, a_ok, a_err, a_runt, a_over;
    logic [31:0] a_crc;
    logic [15:0] a_fcnt, a_ecnt;
    logic        b_ready, b_busy, b_done, b_ok, b_err, b_runt, b_over;
    logic [31:0] b_crc;
    logic [15:0] b_fcnt, b_ecnt;
    logic        m_ready, m_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] frm [0:31];
    int         frm_len;

    always #5 clk = ~clk;

    assign s_valid_a = s_vld & ~sel;
    assign s_valid_b = s_vld & sel;
    assign m_ready   = sel ? b_ready : a_ready;
    assign m_done    = sel ? b_done  : a_done;

    crc32_frame_rx_ctrl u_dut_a (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid_a), .s_last(s_last),
        .s_ready(a_ready), .busy(a_busy), .frame_done(a_done), .frame_ok(a_ok),
        .frame_err(a_err), .err_runt(a_runt), .err_oversize(a_over), .crc_calc(a_crc),
        .frame_count(a_fcnt), .err_count(a_ecnt)
    );

    crc32_frame_rx_ctrl #(.MAX_BYTES(8)) u_dut_b (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last),
        .s_ready(b_ready), .busy(b_busy), .frame_done(b_done), .frame_ok(b_ok),
        .frame_err(b_err), .err_runt(b_runt), .err_oversize(b_over), .crc_calc(b_crc),
        .frame_count(b_fcnt), .err_count(b_ecnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, output int acc);
        acc    = 0;
        s_data = d;
        s_last = last;
        s_vld  = 1'b1;
        for (int k = 0; k < 40 && acc == 0; k++) begin
            if (m_ready) acc = 1;
            tick();
        end
        s_vld  = 1'b0;
        s_last = 1'b0;
        if (acc == 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic ready_low_cycles(output int n);
        n = 0;
        while (!m_ready && n < 20) begin
            n++;
            tick();
        end
    endtask

    // Sends frm[0..frm_len-1]; counts accepted bytes and bad s_ready gaps.
    task automatic send_frame(input int gap_max, output int acc_n, output int rdy_bad);
        int a, n, g;
        acc_n   = 0;
        rdy_bad = 0;
        for (int i = 0; i < frm_len; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) tick();
            send_byte(frm[i], (i == frm_len - 1), a);
            acc_n += a;
            if (i != frm_len - 1) begin
                ready_low_cycles(n);
                if (n != ((i >= 4) ? 8 : 0)) rdy_bad++;
            end
        end
    endtask

    // Latency counted from the accept cycle of the last byte.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (m_done) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic load_ref(input logic [7:0] p4);
        frm[0]  = 8'h31; frm[1]  = 8'h32; frm[2]  = 8'h33; frm[3]  = 8'h34;
        frm[4]  = p4;    frm[5]  = 8'h36; frm[6]  = 8'h37; frm[7]  = 8'h38;
        frm[8]  = 8'h39; frm[9]  = 8'h26; frm[10] = 8'h39; frm[11] = 8'hF4;
        frm[12] = 8'hCB;
        frm_len = 13;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int acc, bad, lat, dcnt, a;
        rst = 1'b1; s_vld = 1'b0; s_last = 1'b0; s_data = 8'h00; sel = 1'b0;
        repeat (3) tick();
        chk("rst_ready",  32'(a_ready), 32'd0);
        chk("rst_busy",   32'(a_busy),  32'd0);
        chk("rst_done",   32'(a_done),  32'd0);
        chk("rst_fcnt",   32'(a_fcnt),  32'd0);
        chk("rst_b_busy", 32'(b_busy),  32'd0);
        rst = 1'b0;
        tick();
        chk("ready_rise", 32'(a_ready), 32'd1);

        // good "123456789" frame
        load_ref(8'h35);
        send_frame(0, acc, bad);
        wait_done(lat);
        chk("t1_lat",  32'(lat), 32'd10);
        chk("t1_acc",  32'(acc), 32'd13);
        chk("t1_rdy",  32'(bad), 32'd0);
        chk("t1_ok",   32'(a_ok),  32'd1);
        chk("t1_err",  32'(a_err), 32'd0);
        chk("t1_over", 32'(a_over), 32'd0);
        chk("t1_crc",  a_crc, 32'hCBF43926);
        chk("t1_fcnt", 32'(a_fcnt), 32'd1);
        chk("t1_ecnt", 32'(a_ecnt), 32'd0);
        chk("t1_busy", 32'(a_busy), 32'd0);
        chk("t1_rdy_next", 32'(a_ready), 32'd1);
        tick();
        chk("t1_pulse", 32'(a_done), 32'd0);
        chk("t1_hold",  32'(a_ok),   32'd1);

        // corrupted payload byte
        load_ref(8'h36);
        send_frame(0, acc, bad);
        wait_done(lat);
        chk("t2_lat",  32'(lat), 32'd10);
        chk("t2_ok",   32'(a_ok),   32'd0);
        chk("t2_err",  32'(a_err),  32'd1);
        chk("t2_runt", 32'(a_runt), 32'd0);
        chk("t2_ecnt", 32'(a_ecnt), 32'd1);
        chk("t2_fcnt", 32'(a_fcnt), 32'd2);

        // 3-byte runt, then a good frame
        frm[0] = 8'hAA; frm[1] = 8'hBB; frm[2] = 8'hCC; frm_len = 3;
        send_frame(0, acc, bad);
        wait_done(lat);
        chk("t3_lat",  32'(lat), 32'd2);
        chk("t3_err",  32'(a_err),  32'd1);
        chk("t3_ok",   32'(a_ok),   32'd0);
        chk("t3_runt", 32'(a_runt), 32'd1);
        chk("t3_ecnt", 32'(a_ecnt), 32'd2);
        load_ref(8'h35);
        send_frame(0, acc, bad);
        wait_done(lat);
        chk("t3b_ok",   32'(a_ok),   32'd1);
        chk("t3b_runt", 32'(a_runt), 32'd0);
        chk("t3b_fcnt", 32'(a_fcnt), 32'd4);

        // back-to-back frames with random valid gaps
        for (int f = 0; f < 2; f++) begin
            load_ref(8'h35);
            send_frame(5, acc, bad);
            wait_done(lat);
            chk("t4_lat", 32'(lat), 32'd10);
            chk("t4_rdy", 32'(bad), 32'd0);
            chk("t4_ok",  32'(a_ok), 32'd1);
            chk("t4_rdy_next", 32'(a_ready), 32'd1);
        end
        chk("t4_fcnt", 32'(a_fcnt), 32'd6);
        chk("t4_ecnt", 32'(a_ecnt), 32'd2);

        // oversize on the MAX_BYTES=8 instance, then a 5-byte "a" frame
        sel = 1'b1;
        for (int i = 0; i < 12; i++) frm[i] = 8'h10 + 8'(i);
        frm_len = 12;
        send_frame(0, acc, bad);
        wait_done(lat);
        chk("t5_acc",  32'(acc), 32'd12);
        chk("t5_lat",  32'(lat), 32'd10);
        chk("t5_err",  32'(b_err),  32'd1);
        chk("t5_ok",   32'(b_ok),   32'd0);
        chk("t5_over", 32'(b_over), 32'd1);
        chk("t5_runt", 32'(b_runt), 32'd0);
        chk("t5_ecnt", 32'(b_ecnt), 32'd1);
        frm[0] = 8'h61; frm[1] = 8'h43; frm[2] = 8'hBE; frm[3] = 8'hB7; frm[4] = 8'hE8;
        frm_len = 5;
        send_frame(0, acc, bad);
        wait_done(lat);
        chk("t5b_lat",  32'(lat), 32'd10);
        chk("t5b_ok",   32'(b_ok),   32'd1);
        chk("t5b_over", 32'(b_over), 32'd0);
        chk("t5b_crc",  b_crc, 32'hE8B7BE43);
        chk("t5b_fcnt", 32'(b_fcnt), 32'd2);
        chk("t5b_ecnt", 32'(b_ecnt), 32'd1);

        // reset in the middle of a frame
        sel = 1'b0;
        load_ref(8'h35);
        for (int i = 0; i < 6; i++) send_byte(frm[i], 1'b0, a);
        dcnt = 0;
        rst = 1'b1;
        repeat (2) begin tick(); if (a_done) dcnt++; end
        rst = 1'b0;
        repeat (12) begin tick(); if (a_done) dcnt++; end
        chk("t6_nodone", 32'(dcnt), 32'd0);
        chk("t6_fcnt",   32'(a_fcnt), 32'd0);
        chk("t6_ecnt",   32'(a_ecnt), 32'd0);
        chk("t6_ok0",    32'(a_ok),   32'd0);
        send_frame(0, acc, bad);
        wait_done(lat);
        chk("t6_ok",   32'(a_ok),   32'd1);
        chk("t6_crc",  a_crc, 32'hCBF43926);
        chk("t6_fcnt", 32'(a_fcnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
